// File: rtl/uart_txd.sv
// uart_txd: UART transmitter. Pops bytes from a first-word-fall-through TX
// FIFO and sends each one on o_txd as a frame: a start bit, 8 data bits
// (LSB first), an optional parity bit, then 1 or 2 stop bits.
// The line idles high. The frame format and the bit period are latched when
// the byte is popped, so later configuration changes do not affect that frame.
// Optional line-break support is enabled by defining UART_TXD_BREAK_EN.
//
// FIFO handshake (valid/ready):
//   - i_fifo_notempty is "valid" for i_fifo_data.
//   - o_fifo_rd is the pop strobe. It is high for exactly one clock.
//   - The FIFO advances on the clock edge that ends that o_fifo_rd cycle.
//   - The byte is captured at the edge that raises o_fifo_rd, so data is
//     never taken from the next FIFO head.
//
// The current FSM state is visible on o_dbg_state.
module uart_txd #(
  parameter int DATA_W = 8
) (
  input  logic              i_uart_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_fifo_notempty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd,
  input  logic [1:0]        i_cfg_txd_parity,
  input  logic [1:0]        i_cfg_txd_sample,
  input  logic              i_cfg_txd_stop,
  output logic              o_txd,
  output logic              o_busy,
`ifdef UART_TXD_BREAK_EN
  input  logic              i_break,
`endif
  output logic [2:0]        o_dbg_state
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e              state_q;
  logic [5:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic                par_en_q;
  logic                par_odd_q;
  logic [5:0]          dm1_q;
  logic                stop2_q;
  logic                txd_q;
  logic                busy_q;
  logic                rd_q;

  logic [5:0]          cfg_dm1_d;
  logic                start_frame_d;
  logic                wrap_d;
  logic                par_bit_d;
  logic                hold_d;
  logic                idle_line_d;

  // Decode the live bit-period field into D-1 (the baud counter's wrap value).
  always_comb begin
    cfg_dm1_d = 6'd63;
    case (i_cfg_txd_sample)
      2'b00:   cfg_dm1_d = 6'd7;
      2'b01:   cfg_dm1_d = 6'd15;
      2'b10:   cfg_dm1_d = 6'd31;
      default: cfg_dm1_d = 6'd63;
    endcase
  end

`ifdef UART_TXD_BREAK_EN
  // Mark-after-break down-counter. It counts the high time owed before the
  // next pop is allowed.
  logic [7:0] mab_q;

  // Reload with 2*D while break is held in IDLE, then count the mark time down.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mab_q <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      if (i_break) begin
        mab_q <= {1'b0, cfg_dm1_d, 1'b0} + 8'd2;
      end else if (mab_q != 8'd0) begin
        mab_q <= mab_q - 8'd1;
      end
    end
  end

  assign hold_d      = i_break || (mab_q != 8'd0);
  assign idle_line_d = ~i_break;
`else
  assign hold_d      = 1'b0;
  assign idle_line_d = 1'b1;
`endif

  assign start_frame_d = (state_q == ST_IDLE) && i_enable && i_fifo_notempty && !hold_d;
  assign wrap_d        = (cnt_q == dm1_q);
  assign par_bit_d     = (^data_q) ^ par_odd_q;

  // Frame FSM. o_txd and o_busy are registered from the current state, so
  // the line lags the state by one clock; the start bit then begins on the
  // edge after the pop cycle.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      dm1_q     <= '0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      rd_q  <= 1'b0;
      cnt_q <= cnt_q + 6'd1;
      case (state_q)
        ST_IDLE: begin
          txd_q  <= idle_line_d;
          busy_q <= start_frame_d;
          cnt_q  <= '0;
          idx_q  <= '0;
          if (start_frame_d) begin
            rd_q      <= 1'b1;
            data_q    <= i_fifo_data;
            par_en_q  <= ^i_cfg_txd_parity;
            par_odd_q <= (i_cfg_txd_parity == 2'b01);
            dm1_q     <= cfg_dm1_d;
            stop2_q   <= i_cfg_txd_stop;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          txd_q  <= 1'b0;
          busy_q <= 1'b1;
          if (wrap_d) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          txd_q  <= data_q[idx_q];
          busy_q <= 1'b1;
          if (wrap_d) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          txd_q  <= par_bit_d;
          busy_q <= 1'b1;
          if (wrap_d) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b1;
          if (wrap_d) begin
            cnt_q <= '0;
            // idx_q counts the stop bits already sent when two are configured.
            if (stop2_q && (idx_q == '0)) begin
              idx_q <= 1'b1;
            end else begin
              idx_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_rd   = rd_q;
  assign o_txd       = txd_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_txd.sv
// tb_uart_txd: directed bench for uart_txd. A small FWFT FIFO model feeds the
// DUT. Each expected line level is queued when a frame is set up, and one
// level is popped and compared on every clock of that frame.
module tb_uart_txd;

  localparam int W = 1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       notempty;
  logic [7:0] fdata;
  logic       rd;
  logic [1:0] par;
  logic [1:0] samp;
  logic       stop;
  logic       txd;
  logic       busy;
  logic [2:0] dbg;
`ifdef UART_TXD_BREAK_EN
  logic       brk;
`endif

  logic [W-1:0] exp_q[$];
  logic [7:0]   fifo_q[$];
  int           checks;
  int           errors;
  int           cyc;

  uart_txd dut (
    .i_uart_clk       (clk),
    .i_rst_n          (rst_n),
    .i_enable         (en),
    .i_fifo_notempty  (notempty),
    .i_fifo_data      (fdata),
    .o_fifo_rd        (rd),
    .i_cfg_txd_parity (par),
    .i_cfg_txd_sample (samp),
    .i_cfg_txd_stop   (stop),
    .o_txd            (txd),
    .o_busy           (busy),
`ifdef UART_TXD_BREAK_EN
    .i_break          (brk),
`endif
    .o_dbg_state      (dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    notempty = (fifo_q.size() != 0);
    fdata    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  // Advance one clock. Afterwards, sample 1 ns past the rising edge. The FIFO
  // pops if o_fifo_rd was high during the cycle that just ended.
  task automatic tick();
    logic rd_s;
    rd_s = rd;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pop(input int budget, input string tag);
    int n;
    n = 0;
    while (rd !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, rd}, 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic build_frame(input logic [7:0] b, input logic [1:0] pm, input int d, input logic s2);
    logic p;
    for (int i = 0; i < d; i++) exp_q.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < d; i++) exp_q.push_back(b[j]);
    if (pm == 2'b01 || pm == 2'b10) begin
      p = ^b;
      if (pm == 2'b01) p = ~p;
      for (int i = 0; i < d; i++) exp_q.push_back(p);
    end
    for (int i = 0; i < (s2 ? 2 * d : d); i++) exp_q.push_back(1'b1);
  endtask

  // Called from the pop cycle. Drains the expected queue one clock at a time.
  task automatic check_frame(input string tag, input int drop_at);
    int n;
    logic [W-1:0] e;
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      if (k == drop_at) en = 1'b0;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("%s txd clk %0d", tag, k), {31'd0, txd}, {31'd0, e});
      chk($sformatf("%s busy clk %0d", tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s rd clk %0d", tag, k), {31'd0, rd}, 32'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    tick();
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " txd"}, {31'd0, txd}, 32'd1);
    chk({tag, " rd"}, {31'd0, rd}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p1;
    int rd_n;
    int txd_n;
    int busy_n;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    par    = 2'b00;
    samp   = 2'b00;
    stop   = 1'b0;
`ifdef UART_TXD_BREAK_EN
    brk    = 1'b0;
`endif
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    chk("reset txd", {31'd0, txd}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rd", {31'd0, rd}, 32'd0);
    chk("reset state", {29'd0, dbg}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Even parity, D=8, one stop bit, byte 0x5B.
    par = 2'b10; samp = 2'b00; stop = 1'b0;
    push(8'h5B);
    en = 1'b1;
    wait_pop(10, "t1 pop");
    build_frame(8'h5B, 2'b10, 8, 1'b0);
    check_frame("t1", 0);
    check_idle("t1 idle");

    // Odd parity, D=16, two stop bits, byte 0x00. The configuration changes
    // mid-frame and must not affect the frame already being sent.
    par = 2'b01; samp = 2'b01; stop = 1'b1;
    push(8'h00);
    wait_pop(10, "t2 pop");
    par = 2'b00; samp = 2'b11; stop = 1'b0;
    build_frame(8'h00, 2'b01, 16, 1'b1);
    check_frame("t2", 0);
    check_idle("t2 idle");

    // No parity, D=8, two bytes back-to-back.
    par = 2'b00; samp = 2'b00; stop = 1'b0;
    push(8'hA5);
    push(8'h3C);
    wait_pop(10, "t3 pop a");
    p1 = cyc;
    build_frame(8'hA5, 2'b00, 8, 1'b0);
    check_frame("t3a", 0);
    wait_pop(5, "t3 pop b");
    chk("t3 pop gap", cyc - p1, 32'd81);
    build_frame(8'h3C, 2'b00, 8, 1'b0);
    check_frame("t3b", 0);
    check_idle("t3 idle");

    // FIFO empty with the transmitter enabled.
    rd_n = 0; txd_n = 0; busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rd !== 1'b0) rd_n++;
      if (txd !== 1'b1) txd_n++;
      if (busy !== 1'b0) busy_n++;
    end
    chk("t4 empty rd", rd_n, 32'd0);
    chk("t4 empty txd", txd_n, 32'd0);
    chk("t4 empty busy", busy_n, 32'd0);

    // Byte present but the transmitter disabled.
    en = 1'b0;
    push(8'hFF);
    rd_n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd !== 1'b0) rd_n++;
    end
    chk("t4 disabled rd", rd_n, 32'd0);

    // Reset asserted during data bit 3 of a 0xFF frame.
    en = 1'b1;
    wait_pop(10, "t5a pop");
    repeat (35) tick();
    chk("t5a txd bit3", {31'd0, txd}, 32'd1);
    chk("t5a busy bit3", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5a rst txd", {31'd0, txd}, 32'd1);
    chk("t5a rst busy", {31'd0, busy}, 32'd0);
    chk("t5a rst state", {29'd0, dbg}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check_idle("t5a after rst");
    push(8'hFF);
    wait_pop(10, "t5a repop");
    build_frame(8'hFF, 2'b00, 8, 1'b0);
    check_frame("t5a clean", 0);
    check_idle("t5a idle");

    // Enable dropped during data bit 3. The frame completes and nothing more
    // is popped.
    push(8'hFF);
    push(8'h55);
    wait_pop(10, "t5b pop");
    build_frame(8'hFF, 2'b00, 8, 1'b0);
    check_frame("t5b", 33);
    rd_n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd !== 1'b0) rd_n++;
    end
    chk("t5b no pop", rd_n, 32'd0);
    chk("t5b fifo left", fifo_q.size(), 32'd1);
    chk("t5b txd", {31'd0, txd}, 32'd1);
    chk("t5b busy", {31'd0, busy}, 32'd0);

`ifdef UART_TXD_BREAK_EN
    // Break held while idle, then mark-after-break before the next pop.
    par = 2'b00; samp = 2'b00; stop = 1'b0;
    brk = 1'b1;
    en  = 1'b1;
    rd_n = 0; txd_n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd !== 1'b0) rd_n++;
      if (txd !== 1'b0) txd_n++;
    end
    chk("brk no pop", rd_n, 32'd0);
    chk("brk line low", txd_n, 32'd0);
    brk = 1'b0;
    p1 = 0; txd_n = 0;
    for (int i = 0; i < 200 && rd !== 1'b1; i++) begin
      tick();
      if (rd !== 1'b1) begin
        if (txd === 1'b1) p1++;
        else txd_n++;
      end
    end
    chk("brk pop after mark", {31'd0, rd}, 32'd1);
    chk("brk mark no low", txd_n, 32'd0);
    chk("brk mark long", {31'd0, (p1 >= 16)}, 32'd1);
    build_frame(8'h55, 2'b00, 8, 1'b0);
    check_frame("brk frame", 0);
    check_idle("brk idle");
`else
    // Drain the remaining byte at D=32, even parity, two stop bits.
    par = 2'b10; samp = 2'b10; stop = 1'b1;
    en  = 1'b1;
    wait_pop(10, "t6 pop");
    build_frame(8'h55, 2'b10, 32, 1'b1);
    check_frame("t6", 0);
    check_idle("t6 idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
